// File: rtl/ip_csum_stream_pkg.sv
// Shared definitions for the streaming Internet checksum engine.
// Holds the FSM state type, the lane-count constants and the ones'-complement helpers.
package ip_csum_stream_pkg;

  // Widest accumulator that csum_fold handles. Callers zero-extend narrower sums.
  localparam int unsigned CSUM_MAX_W = 64;

  typedef enum logic [2:0] {
    ACC,
    DRAIN,
    FOLD1,
    FOLD2,
    OUT
  } csum_state_t;

  // Number of 16-bit words carried by one beat.
  function automatic int unsigned csum_lane_count(input int unsigned data_w);
    return data_w / 16;
  endfunction

  // Extra bits needed by the lane adder tree above 16.
  function automatic int unsigned csum_lane_log2(input int unsigned data_w);
    return $clog2(data_w / 16);
  endfunction

  // Width of the registered lane sum.
  function automatic int unsigned csum_lane_w(input int unsigned data_w);
    return 16 + $clog2(data_w / 16);
  endfunction

  // End-around-carry add of two 16-bit words.
  function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Fold a wide partial sum down to 16 bits. Five folds settle any 64-bit value.
  function automatic logic [15:0] csum_fold(input logic [CSUM_MAX_W-1:0] v);
    logic [CSUM_MAX_W-1:0] s;
    s = v;
    for (int unsigned i = 0; i < 5; i++) begin
      s = {{(CSUM_MAX_W-16){1'b0}}, s[15:0]} + {16'd0, s[CSUM_MAX_W-1:16]};
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/ip_csum_lane_tree.sv
// Combinational keep-masked word adder tree.
// Word k is {byte 2k, byte 2k+1}; bytes with keep=0 read as zero.
module ip_csum_lane_tree
  import ip_csum_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]                    data,
  input  logic [DATA_W/8-1:0]                  keep,
  output logic [csum_lane_w(DATA_W)-1:0]       lane_sum
);

  localparam int unsigned LANES = csum_lane_count(DATA_W);
  localparam int unsigned LOG2  = csum_lane_log2(DATA_W);
  localparam int unsigned LW    = csum_lane_w(DATA_W);
  // Leaves are padded to a power of two; unused leaves are zero.
  localparam int unsigned P     = 2 ** LOG2;

  // Heap-ordered tree: node[1] is the root, leaves sit at node[P..2P-1].
  logic [LW-1:0] node [1:2*P-1];

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < LANES) begin : g_used
      logic [7:0] hi;
      logic [7:0] lo;
      assign hi = keep[2*k]   ? data[16*k +: 8]     : 8'h00;
      assign lo = keep[2*k+1] ? data[16*k+8 +: 8]   : 8'h00;
      assign node[P+k] = LW'({hi, lo});
    end else begin : g_pad
      assign node[P+k] = '0;
    end
  end

  for (genvar n = 1; n < P; n++) begin : g_node
    assign node[n] = node[2*n] + node[2*n+1];
  end

  assign lane_sum = node[1];

endmodule

// File: rtl/ip_csum_stream.sv
// Streaming 16-bit ones'-complement Internet checksum over valid/ready beats.
// Stage 1 registers the keep-masked lane sum, stage 2 accumulates it (seeded on the
// first beat), then two folds produce the complemented result held until accepted.
// Optional macro IP_CSUM_VERIFY_EN adds m_csum_ok (folded sum == 16'hFFFF).
// SUM_W is expected to be at most 64.
module ip_csum_stream
  import ip_csum_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SUM_W  = 32
) (
  input  logic                clk156,
  input  logic                sys_rst,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic [15:0]         s_seed,
  output logic                m_csum_valid,
  input  logic                m_csum_ready,
  output logic [15:0]         m_csum
`ifdef IP_CSUM_VERIFY_EN
  ,
  output logic                m_csum_ok
`endif
);

  localparam int unsigned LW = csum_lane_w(DATA_W);

  csum_state_t       state_q;
  csum_state_t       state_d;
  logic              accept;
  logic              first_q;
  logic              s1_valid_q;
  logic              s1_first_q;
  logic [15:0]       s1_seed_q;
  logic [LW-1:0]     lane_sum_c;
  logic [LW-1:0]     lane_sum_q;
  logic [SUM_W-1:0]  acc_q;
  logic [SUM_W-1:0]  acc_base;
  logic [SUM_W-1:0]  acc_fold;
  logic [15:0]       folded;
  logic              out_done;

  ip_csum_lane_tree #(
    .DATA_W(DATA_W)
  ) u_lane_tree (
    .data     (s_tdata),
    .keep     (s_tkeep),
    .lane_sum (lane_sum_c)
  );

  assign accept   = s_tvalid && s_tready;
  assign out_done = (state_q == OUT) && m_csum_ready;
  assign acc_base = s1_first_q ? SUM_W'(s1_seed_q) : acc_q;
  assign acc_fold = SUM_W'(acc_q[15:0]) + SUM_W'(acc_q[SUM_W-1:16]);
  // After FOLD1 the value fits in 17 bits, so the full fold equals one more fold step.
  assign folded   = csum_fold(CSUM_MAX_W'(acc_q));

  // FSM state register.
  always_ff @(posedge clk156) begin
    if (sys_rst) state_q <= ACC;
    else         state_q <= state_d;
  end

  // Next-state and input-ready decode.
  always_comb begin
    state_d  = state_q;
    s_tready = 1'b0;
    case (state_q)
      ACC: begin
        s_tready = 1'b1;
        if (accept && s_tlast) state_d = DRAIN;
      end
      DRAIN: state_d = FOLD1;
      FOLD1: state_d = FOLD2;
      FOLD2: state_d = OUT;
      OUT:   if (m_csum_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // First-beat flag: cleared by any accepted beat, re-armed by the result handshake.
  always_ff @(posedge clk156) begin
    if (sys_rst)       first_q <= 1'b1;
    else if (accept)   first_q <= 1'b0;
    else if (out_done) first_q <= 1'b1;
  end

  // Stage 1: register lane sum, seed and first flag alongside the beat.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_seed_q  <= '0;
      lane_sum_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= first_q;
        s1_seed_q  <= s_seed;
        lane_sum_q <= lane_sum_c;
      end
    end
  end

  // Stage 2 accumulate, then two end-around folds, then clear after handshake.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      acc_q <= '0;
    end else begin
      case (state_q)
        FOLD1, FOLD2: acc_q <= acc_fold;
        OUT:          if (m_csum_ready) acc_q <= '0;
        default:      if (s1_valid_q) acc_q <= acc_base + SUM_W'(lane_sum_q);
      endcase
    end
  end

  // Result register: loaded in FOLD2, held through OUT until accepted.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      m_csum_valid <= 1'b0;
      m_csum       <= '0;
    end else if (state_q == FOLD2) begin
      m_csum_valid <= 1'b1;
      m_csum       <= ~folded;
    end else if (out_done) begin
      m_csum_valid <= 1'b0;
    end
  end

`ifdef IP_CSUM_VERIFY_EN
  // Verification flag: the data already carried a correct checksum.
  always_ff @(posedge clk156) begin
    if (sys_rst)               m_csum_ok <= 1'b0;
    else if (state_q == FOLD2) m_csum_ok <= (folded == 16'hFFFF);
  end
`endif

endmodule
